// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: fixed priority ld > md > ex with per-source
// aging, final writeback data formation, and registered write-port outputs.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CONF_W       = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [4:0]        ld_rd,
    input  logic [31:0]       ld_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [4:0]        md_rd,
    input  logic [31:0]       md_data,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [4:0]        ex_rd,
    input  logic [2:0]        ex_sel,
    input  logic [31:0]       ex_alu_data,
    input  logic [31:0]       ex_pc,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [2:0]        rf_wd_sel,
    output logic [CONF_W-1:0] conflict_cnt
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    localparam logic [2:0] SEL_ALU_C = 3'b000;
    localparam logic [2:0] SEL_MEM_C = 3'b001;
    localparam logic [2:0] SEL_PC_C  = 3'b010;
    localparam logic [2:0] SEL_MDU_C = 3'b011;

    function automatic logic at_least_two(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    logic [2:0]       valid_s;
    logic [2:0]       starved_s;
    logic [2:0]       cand_s;
    logic [2:0]       grant_s;
    logic [2:0][3:0]  wait_r;
    logic [4:0]       win_rd_s;
    logic [31:0]      win_data_s;
    logic [2:0]       win_code_s;

    // Starved sources form the candidate set when any exist; priority picks one.
    always_comb begin
        valid_s = {ex_valid, md_valid, ld_valid};
        for (int i = 0; i < 3; i++) begin
            starved_s[i] = valid_s[i] && (wait_r[i] == LIMIT_C);
        end
        if (|starved_s) begin
            cand_s = starved_s;
        end else begin
            cand_s = valid_s;
        end
        if (cand_s[0]) begin
            grant_s = 3'b001;
        end else if (cand_s[1]) begin
            grant_s = 3'b010;
        end else if (cand_s[2]) begin
            grant_s = 3'b100;
        end else begin
            grant_s = 3'b000;
        end
    end

    assign ld_ready = grant_s[0] & resetn;
    assign md_ready = grant_s[1] & resetn;
    assign ex_ready = grant_s[2] & resetn;

    // Winner's destination, data and source code; PC-link wraps at 32 bits.
    always_comb begin
        win_rd_s   = 5'd0;
        win_data_s = 32'd0;
        win_code_s = SEL_ALU_C;
        case (grant_s)
            3'b001: begin
                win_rd_s   = ld_rd;
                win_data_s = ld_data;
                win_code_s = SEL_MEM_C;
            end
            3'b010: begin
                win_rd_s   = md_rd;
                win_data_s = md_data;
                win_code_s = SEL_MDU_C;
            end
            3'b100: begin
                win_rd_s = ex_rd;
                if (ex_sel == SEL_PC_C) begin
                    win_data_s = ex_pc + 32'd4;
                    win_code_s = SEL_PC_C;
                end else begin
                    win_data_s = ex_alu_data;
                    win_code_s = SEL_ALU_C;
                end
            end
            default: begin
                win_rd_s   = 5'd0;
                win_data_s = 32'd0;
                win_code_s = SEL_ALU_C;
            end
        endcase
    end

    // Per-source aging counters, saturating at the starvation limit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_r <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!valid_s[i] || grant_s[i]) begin
                    wait_r[i] <= 4'd0;
                end else if (wait_r[i] < LIMIT_C) begin
                    wait_r[i] <= wait_r[i] + 4'd1;
                end else begin
                    wait_r[i] <= wait_r[i];
                end
            end
        end
    end

    // Registered write port; r0 writes keep the source code but suppress the write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= 32'd0;
            rf_wd_sel <= 3'b000;
        end else if ((|grant_s) && (win_rd_s != 5'd0)) begin
            rf_we     <= 1'b1;
            rf_waddr  <= win_rd_s;
            rf_wdata  <= win_data_s;
            rf_wd_sel <= win_code_s;
        end else begin
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= 32'd0;
            rf_wd_sel <= win_code_s;
        end
    end

    // Saturating count of cycles with two or more requesters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            conflict_cnt <= '0;
        end else if (at_least_two(valid_s) && (conflict_cnt != {CONF_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CONF_W'(1);
        end else begin
            conflict_cnt <= conflict_cnt;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_wb_port_arbiter;

    localparam int LIMIT  = 4;
    localparam int CONF_W = 4;
    localparam int CONF_MAX = (1 << CONF_W) - 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic ld_valid = 1'b0, md_valid = 1'b0, ex_valid = 1'b0;
    logic ld_ready, md_ready, ex_ready;
    logic [4:0] ld_rd = 5'd0, md_rd = 5'd0, ex_rd = 5'd0;
    logic [31:0] ld_data = 32'd0, md_data = 32'd0, ex_alu_data = 32'd0, ex_pc = 32'd0;
    logic [2:0] ex_sel = 3'b000;
    logic rf_we;
    logic [4:0] rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0] rf_wd_sel;
    logic [CONF_W-1:0] conflict_cnt;

    int total = 0;
    int bad = 0;

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .CONF_W(CONF_W)) dut (
        .clk(clk), .resetn(resetn),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_sel(ex_sel),
        .ex_alu_data(ex_alu_data), .ex_pc(ex_pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_wd_sel(rf_wd_sel), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: how many cycles each source has lost, and what the
    // write port must show in the coming cycle.
    int m_lost [3] = '{0, 0, 0};
    int m_conf = 0;
    logic exp_we = 1'b0;
    logic [4:0] exp_waddr = 5'd0;
    logic [31:0] exp_wdata = 32'd0;
    logic [2:0] exp_sel = 3'b000;

    always @(negedge clk) begin : model
        logic [2:0] v;
        int winner;
        int nvalid;
        logic [4:0] rd;
        logic [31:0] d;
        logic [2:0] code;
        if (!resetn) begin
            chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
            chk("rst_md_ready", {31'd0, md_ready}, 32'd0);
            chk("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
            chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
            chk("rst_rf_wdata", rf_wdata, 32'd0);
            chk("rst_conflict", {28'd0, conflict_cnt}, 32'd0);
            m_lost = '{0, 0, 0};
            m_conf = 0;
            exp_we = 1'b0; exp_waddr = 5'd0; exp_wdata = 32'd0; exp_sel = 3'b000;
        end else begin
            v = {ex_valid, md_valid, ld_valid};
            winner = -1;
            for (int i = 0; i < 3; i++)
                if (winner < 0 && v[i] && m_lost[i] >= LIMIT) winner = i;
            for (int i = 0; i < 3; i++)
                if (winner < 0 && v[i]) winner = i;
            chk("ld_ready", {31'd0, ld_ready}, {31'd0, winner == 0});
            chk("md_ready", {31'd0, md_ready}, {31'd0, winner == 1});
            chk("ex_ready", {31'd0, ex_ready}, {31'd0, winner == 2});
            chk("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
            chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, exp_waddr});
            chk("rf_wdata", rf_wdata, exp_wdata);
            chk("rf_wd_sel", {29'd0, rf_wd_sel}, {29'd0, exp_sel});
            chk("conflict_cnt", {28'd0, conflict_cnt}, m_conf);
            rd = 5'd0; d = 32'd0; code = 3'b000;
            if (winner == 0) begin rd = ld_rd; d = ld_data; code = 3'b001; end
            if (winner == 1) begin rd = md_rd; d = md_data; code = 3'b011; end
            if (winner == 2) begin
                rd = ex_rd;
                if (ex_sel == 3'b010) begin d = ex_pc + 32'd4; code = 3'b010; end
                else begin d = ex_alu_data; code = 3'b000; end
            end
            exp_we = (winner >= 0) && (rd != 5'd0);
            exp_waddr = exp_we ? rd : 5'd0;
            exp_wdata = exp_we ? d : 32'd0;
            exp_sel = code;
            for (int i = 0; i < 3; i++)
                m_lost[i] = (v[i] && winner != i) ? ((m_lost[i] < LIMIT) ? m_lost[i] + 1 : LIMIT) : 0;
            nvalid = int'(v[0]) + int'(v[1]) + int'(v[2]);
            if (nvalid >= 2 && m_conf < CONF_MAX) m_conf = m_conf + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] hs;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_we", {31'd0, rf_we}, 32'd0);
        chk("reset_sel", {29'd0, rf_wd_sel}, 32'd0);
        @(posedge clk); #2 resetn = 1'b1;

        // Single PC-link requester
        cyc(); ex_valid = 1'b1; ex_sel = 3'b010; ex_pc = 32'h1C000000; ex_rd = 5'd1;
        neg(); chk("single_ex_ready", {31'd0, ex_ready}, 32'd1);
        cyc(); ex_valid = 1'b0;
        neg(); chk("single_we", {31'd0, rf_we}, 32'd1);
        chk("single_waddr", {27'd0, rf_waddr}, 32'd1);
        chk("single_wdata", rf_wdata, 32'h1C000004);
        chk("single_sel", {29'd0, rf_wd_sel}, 32'd2);

        // All three valid: ld, md, ex in order
        cyc(); ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'hAAAA0001;
        md_valid = 1'b1; md_rd = 5'd3; md_data = 32'hBBBB0002;
        ex_valid = 1'b1; ex_rd = 5'd4; ex_sel = 3'b000; ex_alu_data = 32'hCCCC0003;
        neg(); chk("all_ld_first", {31'd0, ld_ready}, 32'd1);
        cyc(); ld_valid = 1'b0;
        neg(); chk("all_ld_sel", {29'd0, rf_wd_sel}, 32'd1);
        chk("all_ld_data", rf_wdata, 32'hAAAA0001);
        chk("all_md_second", {31'd0, md_ready}, 32'd1);
        cyc(); md_valid = 1'b0;
        neg(); chk("all_md_sel", {29'd0, rf_wd_sel}, 32'd3);
        chk("all_ex_third", {31'd0, ex_ready}, 32'd1);
        cyc(); ex_valid = 1'b0;
        neg(); chk("all_ex_sel", {29'd0, rf_wd_sel}, 32'd0);
        chk("all_ex_addr", {27'd0, rf_waddr}, 32'd4);
        chk("all_conflict", {28'd0, conflict_cnt}, 32'd2);

        // Starvation: md wins on its fifth cycle despite ld being valid
        cyc(); ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h0; md_valid = 1'b1; md_rd = 5'd7;
        for (int k = 0; k < 4; k++) begin
            neg(); chk("starve_ld_wins", {31'd0, ld_ready}, 32'd1);
            chk("starve_md_waits", {31'd0, md_ready}, 32'd0);
            cyc(); ld_data = ld_data + 32'd1;
        end
        neg(); chk("starve_md_wins", {31'd0, md_ready}, 32'd1);
        cyc(); md_data = 32'h12345678;
        neg(); chk("starve_md_reset", {31'd0, ld_ready}, 32'd1);
        cyc(); ld_valid = 1'b0; md_valid = 1'b0;
        neg();

        // r0 write and PC wrap
        cyc(); ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hDEADBEEF;
        neg(); chk("r0_ready", {31'd0, ld_ready}, 32'd1);
        cyc(); ld_valid = 1'b0;
        neg(); chk("r0_we", {31'd0, rf_we}, 32'd0);
        chk("r0_sel", {29'd0, rf_wd_sel}, 32'd1);
        chk("r0_wdata", rf_wdata, 32'd0);
        cyc(); ex_valid = 1'b1; ex_sel = 3'b010; ex_pc = 32'hFFFFFFFC; ex_rd = 5'd5;
        neg(); chk("wrap_ready", {31'd0, ex_ready}, 32'd1);
        cyc(); ex_valid = 1'b0;
        neg(); chk("wrap_we", {31'd0, rf_we}, 32'd1);
        chk("wrap_wdata", rf_wdata, 32'h0);

        // Reset in the cycle after a grant
        cyc(); ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'h00000088;
        neg(); chk("mid_ld_ready", {31'd0, ld_ready}, 32'd1);
        cyc(); ld_valid = 1'b0; md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99;
        ex_valid = 1'b1; ex_rd = 5'd10; ex_sel = 3'b000; ex_alu_data = 32'hAA;
        chk("mid_we_before", {31'd0, rf_we}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_we_async", {31'd0, rf_we}, 32'd0);
        chk("mid_md_ready", {31'd0, md_ready}, 32'd0);
        chk("mid_conflict", {28'd0, conflict_cnt}, 32'd0);
        @(posedge clk); #2 resetn = 1'b1;
        neg(); chk("regrant_md", {31'd0, md_ready}, 32'd1);
        chk("regrant_ex_wait", {31'd0, ex_ready}, 32'd0);
        cyc(); md_valid = 1'b0;
        neg(); chk("regrant_ex", {31'd0, ex_ready}, 32'd1);
        cyc(); ex_valid = 1'b0;

        // Conflict counter saturation
        cyc(); ld_valid = 1'b1; ld_rd = 5'd11; md_valid = 1'b1; md_rd = 5'd12;
        repeat (20) cyc();
        neg(); chk("conf_saturate", {28'd0, conflict_cnt}, 32'd15);
        cyc(); ld_valid = 1'b0; md_valid = 1'b0;

        // Random traffic honouring the hold-until-handshake contract
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            hs = {ex_valid & ex_ready, md_valid & md_ready, ld_valid & ld_ready};
            @(posedge clk); #1;
            if (!ld_valid || hs[0]) begin
                ld_valid = ($urandom_range(0, 99) < 60);
                ld_rd = 5'($urandom_range(0, 31));
                ld_data = $urandom;
            end
            if (!md_valid || hs[1]) begin
                md_valid = ($urandom_range(0, 99) < 50);
                md_rd = 5'($urandom_range(0, 31));
                md_data = $urandom;
            end
            if (!ex_valid || hs[2]) begin
                ex_valid = ($urandom_range(0, 99) < 70);
                ex_rd = 5'($urandom_range(0, 31));
                ex_sel = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
                ex_alu_data = $urandom;
                ex_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 resetn = 1'b0;
                @(posedge clk); #2 resetn = 1'b1;
            end
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
